// File: rtl/bout_controller.sv
`default_nettype none
// ============================================================================
// Module      : bout_controller
// Description : Match-level sequencer for one fencing bout. Steps through
//               IDLE -> COUNTDOWN -> FIGHT -> POINT -> ... -> OVER, holds the
//               per-player action FSM in reset outside live play, gates the
//               syncer strobe into it, tallies touches and declares a winner.
// Ports       :
//   clk_pixel_in        pixel clock, sole clock
//   rst_in              synchronous active-high reset
//   start_in            start / restart request (honoured in IDLE and OVER)
//   frame_tick_in       one-cycle pulse per video frame
//   syncer_valid_in     frame-data-valid strobe from the syncer
//   point_valid_in      result strobe from the action FSM
//   player_scored_in    local touch flag, qualified by point_valid_in
//   opponent_scored_in  remote touch flag, qualified by point_valid_in
//   syncer_valid_out    syncer strobe passed through only during FIGHT
//   fsm_rst_out         action FSM reset, low only while in FIGHT
//   phase_out           0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 POINT, 4 OVER
//   countdown_out       seconds left while in COUNTDOWN, else 0
//   player_score_out    local touches this bout
//   opponent_score_out  remote touches this bout
//   winner_out          0 none, 1 player, 2 opponent, 3 draw
//   game_over_out       high only in OVER
// Revision    : 1.0  initial release
// ============================================================================
module bout_controller #(
    parameter int FPS           = 60,
    parameter int COUNTDOWN_SEC = 3,
    parameter int PAUSE_FRAMES  = 120,
    parameter int WIN_SCORE     = 5,
    parameter int SCORE_W       = 4
) (
    input  logic               clk_pixel_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               frame_tick_in,
    input  logic               syncer_valid_in,
    input  logic               point_valid_in,
    input  logic               player_scored_in,
    input  logic               opponent_scored_in,
    output logic               syncer_valid_out,
    output logic               fsm_rst_out,
    output logic [2:0]         phase_out,
    output logic [1:0]         countdown_out,
    output logic [SCORE_W-1:0] player_score_out,
    output logic [SCORE_W-1:0] opponent_score_out,
    output logic [1:0]         winner_out,
    output logic               game_over_out
);

    localparam int FC_MAX = (FPS > PAUSE_FRAMES) ? FPS : PAUSE_FRAMES;
    localparam int FC_W   = $clog2(FC_MAX + 1);

    localparam logic [FC_W-1:0]    C_FPS_LAST   = FC_W'(FPS - 1);
    localparam logic [FC_W-1:0]    C_PAUSE_LAST = FC_W'(PAUSE_FRAMES - 1);
    localparam logic [1:0]         C_CD_LOAD    = 2'(COUNTDOWN_SEC);
    localparam logic [SCORE_W-1:0] C_WIN        = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_POINT     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [FC_W-1:0]    frame_q, frame_d;
    logic [1:0]         cd_q, cd_d;
    logic [SCORE_W-1:0] pscore_q, pscore_d;
    logic [SCORE_W-1:0] oscore_q, oscore_d;
    logic [1:0]         winner_q, winner_d;
    logic               fsm_rst_q;
    logic               game_over_q;

    // Candidate scores after a touch, saturating at the winning score.
    logic [SCORE_W-1:0] pscore_inc;
    logic [SCORE_W-1:0] oscore_inc;
    logic               p_reached;
    logic               o_reached;

    always_comb begin
        pscore_inc = pscore_q;
        oscore_inc = oscore_q;
        if (player_scored_in && (pscore_q != C_WIN)) begin
            pscore_inc = pscore_q + SCORE_W'(1);
        end
        if (opponent_scored_in && (oscore_q != C_WIN)) begin
            oscore_inc = oscore_q + SCORE_W'(1);
        end
        p_reached = (pscore_inc == C_WIN);
        o_reached = (oscore_inc == C_WIN);
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        cd_d     = cd_q;
        pscore_d = pscore_q;
        oscore_d = oscore_q;
        winner_d = winner_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_in) begin
                    state_d  = S_COUNTDOWN;
                    cd_d     = C_CD_LOAD;
                    pscore_d = '0;
                    oscore_d = '0;
                    winner_d = 2'd0;
                end
            end

            S_COUNTDOWN: begin
                if (frame_tick_in) begin
                    if (frame_q == C_FPS_LAST) begin
                        frame_d = '0;
                        cd_d    = cd_q - 2'd1;
                        if (cd_q == 2'd1) begin
                            state_d = S_FIGHT;
                        end
                    end else begin
                        frame_d = frame_q + FC_W'(1);
                    end
                end
            end

            S_FIGHT: begin
                // A score event takes priority; a coincident tick is dropped
                // simply because FIGHT never counts ticks.
                if (point_valid_in) begin
                    pscore_d = pscore_inc;
                    oscore_d = oscore_inc;
                    if (p_reached || o_reached) begin
                        state_d  = S_OVER;
                        // Bit 0 = player won, bit 1 = opponent won; both = draw.
                        winner_d = {o_reached, p_reached};
                    end else if (player_scored_in || opponent_scored_in) begin
                        state_d = S_POINT;
                    end
                end
            end

            S_POINT: begin
                if (frame_tick_in) begin
                    if (frame_q == C_PAUSE_LAST) begin
                        state_d = S_COUNTDOWN;
                        cd_d    = C_CD_LOAD;
                    end else begin
                        frame_d = frame_q + FC_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The frame counter restarts from zero on every state entry.
        if (state_d != state_q) begin
            frame_d = '0;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            cd_q        <= 2'd0;
            pscore_q    <= '0;
            oscore_q    <= '0;
            winner_q    <= 2'd0;
            fsm_rst_q   <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cd_q        <= cd_d;
            pscore_q    <= pscore_d;
            oscore_q    <= oscore_d;
            winner_q    <= winner_d;
            // Registered from the next state so it tracks phase_out exactly.
            fsm_rst_q   <= (state_d != S_FIGHT);
            game_over_q <= (state_d == S_OVER);
        end
    end

    assign syncer_valid_out   = syncer_valid_in & (state_q == S_FIGHT);
    assign fsm_rst_out        = fsm_rst_q;
    assign phase_out          = state_q;
    assign countdown_out      = cd_q;
    assign player_score_out   = pscore_q;
    assign opponent_score_out = oscore_q;
    assign winner_out         = winner_q;
    assign game_over_out      = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_bout_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bout_controller
// Description : Randomized self-checking bench for bout_controller against a
//               tick-counting reference model of the bout rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bout_controller;

    localparam int FPS           = 60;
    localparam int COUNTDOWN_SEC = 3;
    localparam int PAUSE_FRAMES  = 120;
    localparam int WIN_SCORE     = 5;
    localparam int SCORE_W       = 4;
    localparam int N_CYCLES      = 50000;

    logic               clk;
    logic               rst_in;
    logic               start_in;
    logic               frame_tick_in;
    logic               syncer_valid_in;
    logic               point_valid_in;
    logic               player_scored_in;
    logic               opponent_scored_in;
    logic               syncer_valid_out;
    logic               fsm_rst_out;
    logic [2:0]         phase_out;
    logic [1:0]         countdown_out;
    logic [SCORE_W-1:0] player_score_out;
    logic [SCORE_W-1:0] opponent_score_out;
    logic [1:0]         winner_out;
    logic               game_over_out;

    int n_checks = 0;
    int n_errors = 0;

    bout_controller #(
        .FPS           (FPS),
        .COUNTDOWN_SEC (COUNTDOWN_SEC),
        .PAUSE_FRAMES  (PAUSE_FRAMES),
        .WIN_SCORE     (WIN_SCORE),
        .SCORE_W       (SCORE_W)
    ) u_dut (
        .clk_pixel_in       (clk),
        .rst_in             (rst_in),
        .start_in           (start_in),
        .frame_tick_in      (frame_tick_in),
        .syncer_valid_in    (syncer_valid_in),
        .point_valid_in     (point_valid_in),
        .player_scored_in   (player_scored_in),
        .opponent_scored_in (opponent_scored_in),
        .syncer_valid_out   (syncer_valid_out),
        .fsm_rst_out        (fsm_rst_out),
        .phase_out          (phase_out),
        .countdown_out      (countdown_out),
        .player_score_out   (player_score_out),
        .opponent_score_out (opponent_score_out),
        .winner_out         (winner_out),
        .game_over_out      (game_over_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase number plus ticks counted since entering the
    // current timed phase; countdown seconds are derived from elapsed ticks.
    int m_phase;
    int m_ticks;
    int m_ps;
    int m_os;
    int m_win;
    int n_overs = 0;
    int n_draws = 0;

    function automatic int m_countdown();
        return (m_phase == 1) ? (COUNTDOWN_SEC - m_ticks / FPS) : 0;
    endfunction

    task automatic model_clear_bout();
        m_phase = 1;
        m_ticks = 0;
        m_ps    = 0;
        m_os    = 0;
        m_win   = 0;
    endtask

    task automatic model_step(input bit rst, input bit start, input bit tick,
                              input bit pv, input bit pf, input bit of);
        if (rst) begin
            m_phase = 0; m_ticks = 0; m_ps = 0; m_os = 0; m_win = 0;
            return;
        end
        case (m_phase)
            0, 4: if (start) model_clear_bout();
            1: if (tick) begin
                m_ticks++;
                if (m_ticks == COUNTDOWN_SEC * FPS) begin
                    m_phase = 2;
                    m_ticks = 0;
                end
            end
            2: if (pv) begin
                if (pf && m_ps < WIN_SCORE) m_ps++;
                if (of && m_os < WIN_SCORE) m_os++;
                if (m_ps == WIN_SCORE || m_os == WIN_SCORE) begin
                    m_phase = 4;
                    m_win   = (m_ps == WIN_SCORE ? 1 : 0) + (m_os == WIN_SCORE ? 2 : 0);
                    n_overs++;
                    if (m_win == 3) n_draws++;
                end else if (pf || of) begin
                    m_phase = 3;
                    m_ticks = 0;
                end
            end
            3: if (tick) begin
                m_ticks++;
                if (m_ticks == PAUSE_FRAMES) begin
                    m_phase = 1;
                    m_ticks = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("phase",     32'(phase_out),          32'(m_phase));
        chk("countdown", 32'(countdown_out),      32'(m_countdown()));
        chk("p_score",   32'(player_score_out),   32'(m_ps));
        chk("o_score",   32'(opponent_score_out), 32'(m_os));
        chk("winner",    32'(winner_out),         32'(m_win));
        chk("fsm_rst",   32'(fsm_rst_out),        32'(m_phase != 2));
        chk("game_over", 32'(game_over_out),      32'(m_phase == 4));
    endtask

    initial begin
        rst_in             = 1'b1;
        start_in           = 1'b0;
        frame_tick_in      = 1'b0;
        syncer_valid_in    = 1'b0;
        point_valid_in     = 1'b0;
        player_scored_in   = 1'b0;
        opponent_scored_in = 1'b0;

        @(posedge clk);
        #1;
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outputs();

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            rst_in             = ($urandom_range(0, 4999) == 0);
            start_in           = ($urandom_range(0, 39) == 0);
            frame_tick_in      = ($urandom_range(0, 3) != 0);
            syncer_valid_in    = $urandom_range(0, 1) != 0;
            point_valid_in     = ($urandom_range(0, 15) == 0);
            // Flag pair skewed so double touches and no-touch events both occur.
            case ($urandom_range(0, 3))
                0: begin player_scored_in = 1'b1; opponent_scored_in = 1'b0; end
                1: begin player_scored_in = 1'b0; opponent_scored_in = 1'b1; end
                2: begin player_scored_in = 1'b1; opponent_scored_in = 1'b1; end
                default: begin player_scored_in = 1'b0; opponent_scored_in = 1'b0; end
            endcase
            #1;
            chk("syncer_valid", 32'(syncer_valid_out),
                32'(syncer_valid_in && (m_phase == 2)));

            @(posedge clk);
            #1;
            model_step(rst_in, start_in, frame_tick_in, point_valid_in,
                       player_scored_in, opponent_scored_in);
            check_outputs();
        end

        $display("bouts finished=%0d draws=%0d", n_overs, n_draws);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
